slot_fifo_arbiter: RTL and testbench
====================================

Name: slot_fifo_arbiter

Overview:
- Shares one 8-bit FIFO write port (2048-deep, 11-bit addresses) between NUM_SLOTS slot converter modules (ADC front ends).
- Grants slots round-robin, one fixed-length burst at a time.
- Prefixes each burst with a header byte identifying the slot.
- Issues a grant only when the FIFO has room for the whole burst. Pads and flags bursts whose slot stalls.

Parameters:
- NUM_SLOTS, 4, number of requesting slots (2..16).
- BURST_LEN, 4, data bytes per burst, excluding header (1..255).
- TIMEOUT, 1024, idle cycles allowed between data bytes before the burst is aborted (≥2).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  0 = no new grants; an in-flight burst completes.
- slot_mask  in  NUM_SLOTS  1 = slot eligible for arbitration.
- slot_req  in  NUM_SLOTS  slot has ≥BURST_LEN bytes ready.
- slot_valid  in  NUM_SLOTS  data strobe from slot; honoured only for the granted slot.
- slot_data  in  8*NUM_SLOTS  byte from slot i on bits [8i+7:8i].
- slot_grant  out  NUM_SLOTS  one-hot grant; all zeros when no grant.
- fifo_data  out  8  byte to FIFO.
- fifo_write  out  1  FIFO write strobe, one byte per high cycle.
- fifo_addr_in  in  11  FIFO write pointer.
- fifo_addr_out  in  11  FIFO read pointer.
- slot_error  out  NUM_SLOTS  sticky per-slot timeout flag.
- error_clear  in  1  clears all slot_error bits.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; rr_ptr=0.
  - slot_grant=0, fifo_write=0, fifo_data=0x00.
  - slot_error=0, busy=0.
- All outputs are registered.
- Free space:
  - used = (fifo_addr_in − fifo_addr_out) mod 2048, 11-bit wrap.
  - free = 2047 − used.
  - Space check passes when free ≥ BURST_LEN+1.
- Eligible set: slot_req & slot_mask.
- IDLE:
  - Go to HEADER when enable=1, eligible≠0 and the space check passes.
  - Winner = first eligible index searching upward from rr_ptr, with wrap.
  - On the HEADER transition: slot_grant[winner] is set, and rr_ptr becomes winner+1 mod NUM_SLOTS.
- HEADER (1 cycle):
  - fifo_write=1.
  - fifo_data = {1'b1, 3'b000, winner[3:0]}.
  - Next state: DATA.
- DATA:
  - Each cycle with slot_valid[winner]=1: the following cycle drives fifo_write=1 and fifo_data = that slot's byte. The byte counter increments and the timeout counter clears.
  - Cycles without valid: fifo_write=0 and the timeout counter increments.
  - slot_valid from non-granted slots is ignored.
  - Normal end: after byte BURST_LEN is accepted, slot_grant is cleared on the next edge and the state goes to SETTLE.
  - Timeout: when the timeout counter reaches TIMEOUT, go to PAD. slot_grant clears and slot_error[winner] sets.
- PAD:
  - Writes 0x00 (fifo_write=1) once per cycle until the total data-byte count equals BURST_LEN.
  - Next state: SETTLE.
  - This keeps FIFO framing intact: every burst is exactly 1+BURST_LEN bytes.
- SETTLE (2 cycles): no writes; lets fifo_addr_in update. Next state: IDLE.
- Latency: a request in IDLE with space gives grant and header write on the next edge. The first data byte reaches the FIFO 1 cycle after its slot_valid.
- Simultaneous events:
  - error_clear and a new timeout on the same cycle: the set wins for that slot.
  - slot_req deasserting mid-burst is ignored; only valid/timeout end a burst.
  - slot_mask or enable changes affect only the next arbitration.
- FIFO full (space check fails): remain in IDLE with no grant. Requests are not lost; the block re-evaluates every cycle.
- Reset mid-burst: immediate return to reset values. The partial burst left in the FIFO is the downstream reader's concern.

Decomposition:
- Shared package (da_platform_pkg) holds:
  - the state encoding (IDLE, HEADER, DATA, PAD, SETTLE);
  - the FIFO address width (11);
  - the header marker bit;
  - the pad byte value (0x00).
- One natural sub-module: rr_select. It is combinational round-robin: takes the eligible vector and rr_ptr, and returns a found flag and the winner index.

Test Plan:
- Single slot: slot_req=0001, FIFO empty. Slot 0 strobes DE, AD, BE, EF → FIFO receives 80, DE, AD, BE, EF; grant 0001 high for 5 cycles; busy returns to 0 after 2 SETTLE cycles.
- Round-robin: slot_req=1111 held → headers arrive in order 80, 81, 82, 83, 80; each burst is 5 bytes.
- Full FIFO: fifo_addr_in=0x7FD, fifo_addr_out=0x001 (free=3) → no grant. Set fifo_addr_out=0x7FD → grant on the next edge.
- Timeout: slot 2 granted, sends 1 byte, then stalls TIMEOUT cycles → FIFO gets 82, xx, 00, 00, 00 and slot_error=0100. Assert error_clear → slot_error=0000.
- Mask/enable: slot_mask=1110 with slot_req=0001 → no grant. enable=0 during a burst → that burst completes, no further grants.
- Async reset mid-DATA: drive reset=0 without a clock edge → grant, fifo_write and busy are 0 immediately; after release, arbitration restarts at slot 0.

Source files
------------

// File: rtl/da_platform_pkg.sv
// rtl/da_platform_pkg.sv - shared types and constants for the slot FIFO arbiter
package da_platform_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_PAD    = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  localparam int FIFO_AW = 11;
  localparam logic [7:0] HDR_MARK = 8'h80;
  localparam logic [7:0] PAD_BYTE = 8'h00;

  function automatic logic [7:0] header_byte(input logic [3:0] idx);
    return HDR_MARK | {4'b0000, idx};
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick: first eligible index at or above rr_ptr, with wrap
module rr_select #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] eligible,
  input  logic [3:0]           rr_ptr,
  output logic                 found,
  output logic [3:0]           winner
);

  function automatic logic [3:0] wrap_idx(input logic [3:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SLOTS) s = s - NUM_SLOTS;
    return 4'(s);
  endfunction

  // Scan from the farthest offset down so the nearest eligible slot is written last.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (|(eligible & (NUM_SLOTS'(1) << wrap_idx(rr_ptr, i)))) begin
        found  = 1'b1;
        winner = wrap_idx(rr_ptr, i);
      end
    end
  end

endmodule

// File: rtl/slot_fifo_arbiter.sv
// rtl/slot_fifo_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among slot converters
module slot_fifo_arbiter
  import da_platform_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SLOTS-1:0]   slot_mask,
  input  logic [NUM_SLOTS-1:0]   slot_req,
  input  logic [NUM_SLOTS-1:0]   slot_valid,
  input  logic [8*NUM_SLOTS-1:0] slot_data,
  output logic [NUM_SLOTS-1:0]   slot_grant,
  output logic [7:0]             fifo_data,
  output logic                   fifo_write,
  input  logic [FIFO_AW-1:0]     fifo_addr_in,
  input  logic [FIFO_AW-1:0]     fifo_addr_out,
  output logic [NUM_SLOTS-1:0]   slot_error,
  input  logic                   error_clear,
  output logic                   busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]         LAST_IDX = 8'(BURST_LEN - 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FIFO_AW-1:0] NEED     = FIFO_AW'(BURST_LEN + 1);
  localparam logic [FIFO_AW-1:0] FIFO_MAX = '1;

  state_t               state, state_next;
  logic [3:0]           rr_ptr, winner, pick;
  logic [7:0]           byte_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic                 settle_cnt;
  logic [NUM_SLOTS-1:0] eligible;
  logic                 found, space_ok, start;
  logic [FIFO_AW-1:0]   used, free_space;
  logic                 win_valid, last_byte, timed_out;
  logic [7:0]           win_byte;
  logic [NUM_SLOTS-1:0] grant_d, err_set;
  logic                 write_d;
  logic [7:0]           data_d;

  assign eligible   = slot_req & slot_mask;
  assign used       = fifo_addr_in - fifo_addr_out;
  assign free_space = FIFO_MAX - used;
  assign space_ok   = free_space >= NEED;
  assign start      = enable && found && space_ok;
  assign win_valid  = |(slot_valid & (NUM_SLOTS'(1) << winner));
  assign last_byte  = byte_cnt == LAST_IDX;
  assign timed_out  = tmo_cnt == TMO_LAST;

  rr_select #(.NUM_SLOTS(NUM_SLOTS)) u_rr_select (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .found    (found),
    .winner   (pick)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (winner == 4'(i)) win_byte = slot_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_HEADER;
      ST_HEADER: state_next = ST_DATA;
      ST_DATA: begin
        if (win_valid && last_byte)       state_next = ST_SETTLE;
        else if (!win_valid && timed_out) state_next = ST_PAD;
      end
      ST_PAD:    if (last_byte) state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the header and each byte land one edge after their decision.
  always_comb begin
    grant_d = slot_grant;
    write_d = 1'b0;
    data_d  = fifo_data;
    err_set = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          grant_d = NUM_SLOTS'(1) << pick;
          write_d = 1'b1;
          data_d  = header_byte(pick);
        end
      end
      ST_DATA: begin
        if (win_valid) begin
          write_d = 1'b1;
          data_d  = win_byte;
          if (last_byte) grant_d = '0;
        end else if (timed_out) begin
          grant_d = '0;
          err_set = NUM_SLOTS'(1) << winner;
        end
      end
      ST_PAD: begin
        write_d = 1'b1;
        data_d  = PAD_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_grant <= '0;
      fifo_write <= 1'b0;
      fifo_data  <= 8'h00;
      slot_error <= '0;
      busy       <= 1'b0;
      rr_ptr     <= 4'd0;
      winner     <= 4'd0;
      byte_cnt   <= 8'd0;
      tmo_cnt    <= '0;
      settle_cnt <= 1'b0;
    end else begin
      slot_grant <= grant_d;
      fifo_write <= write_d;
      fifo_data  <= data_d;
      slot_error <= (error_clear ? '0 : slot_error) | err_set;
      busy       <= state_next != ST_IDLE;
      case (state)
        ST_IDLE: begin
          if (start) begin
            winner     <= pick;
            rr_ptr     <= (pick == 4'(NUM_SLOTS - 1)) ? 4'd0 : pick + 4'd1;
            byte_cnt   <= 8'd0;
            tmo_cnt    <= '0;
            settle_cnt <= 1'b0;
          end
        end
        ST_DATA: begin
          if (win_valid) begin
            byte_cnt <= byte_cnt + 8'd1;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_PAD:    byte_cnt <= byte_cnt + 8'd1;
        ST_SETTLE: settle_cnt <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_fifo_arbiter.sv
// tb/tb_slot_fifo_arbiter.sv - randomized self-checking bench for slot_fifo_arbiter against a transaction-level model
module tb_slot_fifo_arbiter;

  localparam int NS  = 4;
  localparam int BL  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [NS-1:0] slot_mask = '0, slot_req = '0, slot_valid = '0;
  logic [8*NS-1:0] slot_data = '0;
  logic [NS-1:0] slot_grant, slot_error;
  logic [7:0]    fifo_data;
  logic          fifo_write, busy, error_clear = 1'b0;
  logic [10:0]   fifo_addr_in = '0, fifo_addr_out = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int model_rr = 0;
  logic [NS-1:0] model_err = '0;
  logic [7:0] byte_src [BL];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  slot_fifo_arbiter #(.NUM_SLOTS(NS), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .slot_mask(slot_mask),
    .slot_req(slot_req), .slot_valid(slot_valid), .slot_data(slot_data),
    .slot_grant(slot_grant), .fifo_data(fifo_data), .fifo_write(fifo_write),
    .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out),
    .slot_error(slot_error), .error_clear(error_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && fifo_write) got_q.push_back(fifo_data);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_fifo();
    int n;
    check("fifo_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("fifo_byte", got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // One arbitration round; stall_at < 0 means the slot never stalls.
  task automatic run_burst(input logic [NS-1:0] req, input logic [NS-1:0] mask,
                           input int stall_at, input bit gaps, input bit clr, input bit en_drop);
    int w, sent, gcnt, iters, n, free_sp;
    logic [NS-1:0] elig;
    elig = req & mask;
    w = -1;
    for (int i = 0; i < NS; i++) begin
      int k;
      k = (model_rr + i) % NS;
      if (w < 0 && elig[k]) w = k;
    end
    free_sp = 2047 - ((int'(fifo_addr_in) - int'(fifo_addr_out)) & 2047);
    slot_req  = req;
    slot_mask = mask;
    if (w < 0) begin
      repeat (4) @(negedge clk);
      check("no_elig_grant", slot_grant, 0);
      check("no_elig_busy", busy, 0);
      slot_req = '0;
      return;
    end
    if (free_sp < BL + 1) begin
      repeat (3) @(negedge clk);
      check("full_no_grant", slot_grant, 0);
      check("full_busy", busy, 0);
      fifo_addr_in = fifo_addr_out;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (slot_grant == '0 && n < 10);
    check("grant_latency", n, 1);
    check("grant", slot_grant, 32'(1) << w);
    exp_q.push_back(8'h80 | 8'(w));
    model_rr = (w + 1) % NS;
    if (en_drop) enable = 1'b0;
    else         slot_req = '0;
    gcnt = 1;
    iters = 0;
    sent = 0;
    @(negedge clk);
    if (slot_grant != '0) gcnt++;
    while (sent < BL) begin
      slot_valid = NS'($urandom) & ~(NS'(1) << w);
      slot_data  = $urandom;
      if (sent == stall_at) begin
        repeat (TMO - 1) @(negedge clk);
        check("pre_timeout_grant", slot_grant, 32'(1) << w);
        if (clr) error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        model_err = (clr ? '0 : model_err) | (NS'(1) << w);
        check("timeout_grant", slot_grant, 0);
        check("timeout_error", slot_error, model_err);
        for (int p = sent; p < BL; p++) exp_q.push_back(8'h00);
        break;
      end
      if (!(gaps && $urandom_range(0, 2) == 0)) begin
        slot_valid[w] = 1'b1;
        slot_data[8*w +: 8] = byte_src[sent];
        exp_q.push_back(byte_src[sent]);
        sent++;
      end
      iters++;
      @(negedge clk);
      if (slot_grant != '0) gcnt++;
    end
    slot_valid = '0;
    if (sent == BL) begin
      check("grant_cycles", gcnt, 1 + iters);
      check("settle1_busy", busy, 1);
      @(negedge clk);
      check("settle2_busy", busy, 1);
      @(negedge clk);
      check("idle_busy", busy, 0);
    end else begin
      n = 0;
      while (busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("pad_done", busy, 0);
    end
    check("end_grant", slot_grant, 0);
    check("end_error", slot_error, model_err);
    if (en_drop) begin
      repeat (6) @(negedge clk);
      check("enable_off_grant", slot_grant, 0);
      check("enable_off_busy", busy, 0);
      slot_req = '0;
      enable = 1'b1;
    end
    compare_fifo();
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_grant", slot_grant, 0);
    check("rst_write", fifo_write, 0);
    check("rst_data", fifo_data, 0);
    check("rst_error", slot_error, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    byte_src = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_burst(4'b0001, 4'b1111, -1, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < BL; b++) byte_src[b] = 8'($urandom);
      run_burst(4'b1111, 4'b1111, -1, 1'b0, 1'b0, 1'b0);
    end

    fifo_addr_in = 11'h7FD; fifo_addr_out = 11'h001;
    run_burst(4'b0001, 4'b1111, -1, 1'b0, 1'b0, 1'b0);
    fifo_addr_in = 11'd2043; fifo_addr_out = 11'd0;
    run_burst(4'b0010, 4'b1111, -1, 1'b0, 1'b0, 1'b0);
    fifo_addr_in = 11'd2042; fifo_addr_out = 11'd0;
    run_burst(4'b0100, 4'b1111, -1, 1'b0, 1'b0, 1'b0);
    fifo_addr_in = 11'd0;

    byte_src = '{8'h5A, 8'h11, 8'h22, 8'h33};
    model_rr = 2;
    while (model_rr != 2) model_rr = model_rr;
    run_burst(4'b0100, 4'b1111, 1, 1'b0, 1'b0, 1'b0);
    check("err_slot2", slot_error, 4'b0100);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    model_err = '0;
    check("err_cleared", slot_error, 0);

    run_burst(4'b0001, 4'b1110, -1, 1'b0, 1'b0, 1'b0);
    run_burst(4'b1111, 4'b1111, -1, 1'b1, 1'b0, 1'b1);

    for (int r = 0; r < 40; r++) begin
      int used;
      for (int b = 0; b < BL; b++) byte_src[b] = 8'($urandom);
      fifo_addr_out = 11'($urandom);
      used = ($urandom_range(0, 3) == 0) ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
      fifo_addr_in = fifo_addr_out + 11'(used);
      run_burst(NS'($urandom), NS'($urandom) | NS'($urandom),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, BL - 1)) : -1,
                1'b1, 1'($urandom), 1'b0);
      fifo_addr_in = fifo_addr_out;
    end

    slot_req = 4'b0010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (slot_grant == '0 && n < 10);
    slot_req = '0;
    @(negedge clk);
    slot_valid = 4'b0010;
    slot_data  = 32'h0000_7700;
    #2 reset = 1'b0;
    #1;
    check("async_rst_grant", slot_grant, 0);
    check("async_rst_write", fifo_write, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_error", slot_error, 0);
    @(negedge clk);
    reset = 1'b1;
    slot_valid = '0;
    got_q.delete();
    exp_q.delete();
    model_rr = 0;
    model_err = '0;
    for (int b = 0; b < BL; b++) byte_src[b] = 8'($urandom);
    run_burst(4'b1111, 4'b1111, -1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
